ecc_serial_rx: RTL
==================

Name: ecc_serial_rx

Overview:
- Bit-serial input receiver for the ECC core; the receiving end of the operand link that drives the Wrapper (clk/rst, per-bit valid, MSB-first lanes).
- Deserializes the mP frame (mode header plus six parallel operand lanes) and the independent nP frame (two lanes) into parallel words.
- Presents each completed set with a one-cycle done pulse to the point-multiply/add datapath.

Parameters:
- BIT, 32, operand width in bits, applies to every lane.
- CW, 6, counter width; must satisfy 2**CW > BIT.

Ports:
- clk  input  1  system clock; all sampling on posedge.
- rst  input  1  asynchronous active-low reset.
- i_m_P_valid  input  1  mP frame valid; stays high for the whole frame.
- i_mode  input  1  serial mode lane, header only.
- i_a, i_b, i_prime, i_Px, i_Py, i_m  input  1 each  serial operand lanes, MSB first.
- i_nP_valid  input  1  nP frame valid.
- i_nPx, i_nPy  input  1 each  serial nP lanes, MSB first.
- o_mode  output  2  latched mode.
- o_a, o_b, o_prime, o_Px, o_Py, o_m  output  BIT each  latched operands.
- o_mP_done  output  1  one-cycle pulse: mP set updated.
- o_nPx, o_nPy  output  BIT each  latched nP operands.
- o_nP_done  output  1  one-cycle pulse: nP set updated.
- o_frame_err  output  1  one-cycle pulse: a frame was aborted.

Behaviour:
- Reset (rst=0, async): all outputs 0, both FSMs to IDLE, counters 0, shadow shift registers 0.
- mP FSM states: IDLE, START, MODE1, MODE0, DATA, WAIT_LOW.
- IDLE: when i_m_P_valid=1, go to START. The first valid cycle is a start cycle; lanes are ignored.
- START -> MODE1: sample i_mode into mode[1].
- MODE1 -> MODE0: sample i_mode into mode[0].
- MODE0 -> DATA: cnt=BIT-1.
- DATA: each cycle, shift every lane into its shadow register (shift left, new bit at LSB) and decrement cnt.
- DATA end: on the cycle cnt==0 is sampled, go to WAIT_LOW. Next cycle, copy the shadows and header to the o_ registers and assert o_mP_done for exactly 1 cycle. Latency is 1 cycle after the last bit.
- WAIT_LOW: stay until i_m_P_valid=0, then go to IDLE. A new frame needs at least one low cycle between frames.
- nP FSM states: IDLE, DATA, WAIT_LOW. No header.
  - IDLE: if i_nP_valid=1, go to DATA; the first valid cycle is a start cycle, as for mP.
  - DATA: shift i_nPx/i_nPy for BIT cycles.
  - Completion: update o_nPx/o_nPy and pulse o_nP_done 1 cycle after the last bit.
  - WAIT_LOW as for mP.
- The two FSMs are fully independent. Overlapping frames, and done pulses in the same cycle, are legal.
- Abort: valid=0 while in START/MODE1/MODE0/DATA (or nP DATA) returns that FSM to IDLE and pulses o_frame_err for 1 cycle. Output registers keep their previous values, the done pulse is not asserted, and shadow registers are cleared.
- Simultaneous aborts on both channels produce a single o_frame_err pulse.
- Output words change only on done cycles and are stable otherwise.
- X on a lane outside DATA/MODE cycles must not propagate; those cycles are not sampled.
- Reset asserted mid-frame: immediate return to reset values; the partial frame is discarded with no err pulse.

Test Plan:
- Nominal mP frame, BIT=32, mode=2'b10, a=32'h0000_0003, b=32'h0000_0007, prime=32'hFFFF_FFFB, Px=32'h1234_5678, Py=32'h9ABC_DEF0, m=32'h8000_0001 -> o_mP_done pulses once, 1 cycle after the 32nd data bit; all words and o_mode match exactly.
- nP frame nPx=32'hDEAD_BEEF, nPy=32'h0F0F_F0F0, started 5 cycles after the mP frame ends -> o_nP_done single pulse; o_nPx/o_nPy match; mP outputs unchanged.
- Overlap: nP frame start aligned to mP data bit 10, both 32 bits -> both done pulses at their own completion cycles; all values correct.
- Abort: i_m_P_valid dropped after 16 data bits, then a full frame with a=32'h5555_AAAA -> o_frame_err one pulse; prior outputs held; second frame latches correctly with no residue from the partial frame.
- Valid held high 3 extra cycles after the last bit, then low, then a new frame with mode=2'b01 -> no extra done pulse or err; the new frame is received correctly.
- rst pulled low at data bit 20 of a frame -> all outputs 0 immediately; the next full frame is received correctly.

Source files
------------

// File: rtl/ecc_serial_rx_if.sv
// Serial operand link into the ECC core: frame valids, MSB-first lanes,
// and the parallel words/pulses handed on to the datapath.
interface ecc_serial_rx_if #(
  parameter int BIT = 32
);
  logic           i_m_P_valid;
  logic           i_mode;
  logic           i_a;
  logic           i_b;
  logic           i_prime;
  logic           i_Px;
  logic           i_Py;
  logic           i_m;
  logic           i_nP_valid;
  logic           i_nPx;
  logic           i_nPy;
  logic [1:0]     o_mode;
  logic [BIT-1:0] o_a;
  logic [BIT-1:0] o_b;
  logic [BIT-1:0] o_prime;
  logic [BIT-1:0] o_Px;
  logic [BIT-1:0] o_Py;
  logic [BIT-1:0] o_m;
  logic           o_mP_done;
  logic [BIT-1:0] o_nPx;
  logic [BIT-1:0] o_nPy;
  logic           o_nP_done;
  logic           o_frame_err;

  modport master (
    output i_m_P_valid, i_mode, i_a, i_b, i_prime, i_Px, i_Py, i_m,
           i_nP_valid, i_nPx, i_nPy,
    input  o_mode, o_a, o_b, o_prime, o_Px, o_Py, o_m, o_mP_done,
           o_nPx, o_nPy, o_nP_done, o_frame_err
  );

  modport slave (
    input  i_m_P_valid, i_mode, i_a, i_b, i_prime, i_Px, i_Py, i_m,
           i_nP_valid, i_nPx, i_nPy,
    output o_mode, o_a, o_b, o_prime, o_Px, o_Py, o_m, o_mP_done,
           o_nPx, o_nPy, o_nP_done, o_frame_err
  );
endinterface

// File: rtl/ecc_serial_rx.sv
// Deserializer for the ECC operand link: an mP frame (2-bit mode header plus
// six lanes) and an independent nP frame (two lanes), each with a done pulse.
module ecc_serial_rx #(
  parameter int BIT = 32,
  parameter int CW  = 6
) (
  input logic            clk,
  input logic            rst,
  ecc_serial_rx_if.slave rx
);

  localparam int SW = BIT - 1;

  typedef enum logic [2:0] {
    MP_IDLE, MP_START, MP_MODE1, MP_MODE0, MP_DATA, MP_WAIT_LOW
  } mp_state_t;

  typedef enum logic [1:0] {
    NP_IDLE, NP_DATA, NP_WAIT_LOW
  } np_state_t;

  mp_state_t mp_state, mp_next;
  np_state_t np_state, np_next;

  logic mp_hdr1, mp_hdr0, mp_arm, mp_shift, mp_finish, mp_abort;
  logic np_arm, np_shift, np_finish, np_abort;

  logic [CW-1:0] mp_cnt, np_cnt;
  logic [1:0]    mode_sh, mode_q;
  logic [5:0]    mp_lanes;
  logic [1:0]    np_lanes;

  // Shadows keep only BIT-1 bits: the final bit goes straight from the lane
  // into the output word, so the done pulse lands one cycle after it.
  logic [SW-1:0]  mp_sh [6];
  logic [BIT-1:0] mp_q  [6];
  logic [SW-1:0]  np_sh [2];
  logic [BIT-1:0] np_q  [2];
  logic           mp_done_q, np_done_q, err_q;

  assign mp_lanes = {rx.i_a, rx.i_b, rx.i_prime, rx.i_Px, rx.i_Py, rx.i_m};
  assign np_lanes = {rx.i_nPx, rx.i_nPy};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mp_state <= MP_IDLE;
      np_state <= NP_IDLE;
    end else begin
      mp_state <= mp_next;
      np_state <= np_next;
    end
  end

  always_comb begin
    mp_next   = mp_state;
    mp_hdr1   = 1'b0;
    mp_hdr0   = 1'b0;
    mp_arm    = 1'b0;
    mp_shift  = 1'b0;
    mp_finish = 1'b0;
    mp_abort  = 1'b0;
    case (mp_state)
      MP_IDLE:     if (rx.i_m_P_valid) mp_next = MP_START;
      MP_START:    if (!rx.i_m_P_valid) begin
                     mp_abort = 1'b1;
                     mp_next  = MP_IDLE;
                   end else begin
                     mp_hdr1 = 1'b1;
                     mp_next = MP_MODE1;
                   end
      MP_MODE1:    if (!rx.i_m_P_valid) begin
                     mp_abort = 1'b1;
                     mp_next  = MP_IDLE;
                   end else begin
                     mp_hdr0 = 1'b1;
                     mp_next = MP_MODE0;
                   end
      MP_MODE0:    if (!rx.i_m_P_valid) begin
                     mp_abort = 1'b1;
                     mp_next  = MP_IDLE;
                   end else begin
                     mp_arm  = 1'b1;
                     mp_next = MP_DATA;
                   end
      MP_DATA:     if (!rx.i_m_P_valid) begin
                     mp_abort = 1'b1;
                     mp_next  = MP_IDLE;
                   end else begin
                     mp_shift = 1'b1;
                     if (mp_cnt == '0) begin
                       mp_finish = 1'b1;
                       mp_next   = MP_WAIT_LOW;
                     end
                   end
      MP_WAIT_LOW: if (!rx.i_m_P_valid) mp_next = MP_IDLE;
      default:     mp_next = MP_IDLE;
    endcase
  end

  always_comb begin
    np_next   = np_state;
    np_arm    = 1'b0;
    np_shift  = 1'b0;
    np_finish = 1'b0;
    np_abort  = 1'b0;
    case (np_state)
      NP_IDLE:     if (rx.i_nP_valid) begin
                     np_arm  = 1'b1;
                     np_next = NP_DATA;
                   end
      NP_DATA:     if (!rx.i_nP_valid) begin
                     np_abort = 1'b1;
                     np_next  = NP_IDLE;
                   end else begin
                     np_shift = 1'b1;
                     if (np_cnt == '0) begin
                       np_finish = 1'b1;
                       np_next   = NP_WAIT_LOW;
                     end
                   end
      NP_WAIT_LOW: if (!rx.i_nP_valid) np_next = NP_IDLE;
      default:     np_next = NP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mp_cnt    <= '0;
      mode_sh   <= '0;
      mode_q    <= '0;
      mp_done_q <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        mp_sh[i] <= '0;
        mp_q[i]  <= '0;
      end
    end else begin
      mp_done_q <= mp_finish;
      if (mp_abort) begin
        mp_cnt  <= '0;
        mode_sh <= '0;
        for (int i = 0; i < 6; i++) mp_sh[i] <= '0;
      end else begin
        if (mp_hdr1) mode_sh[1] <= rx.i_mode;
        if (mp_hdr0) mode_sh[0] <= rx.i_mode;
        if (mp_arm)  mp_cnt <= CW'(BIT - 1);
        if (mp_shift) begin
          mp_cnt <= mp_finish ? '0 : mp_cnt - CW'(1);
          for (int i = 0; i < 6; i++) mp_sh[i] <= {mp_sh[i][SW-2:0], mp_lanes[i]};
        end
        if (mp_finish) begin
          mode_q <= mode_sh;
          for (int i = 0; i < 6; i++) mp_q[i] <= {mp_sh[i], mp_lanes[i]};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      np_cnt    <= '0;
      np_done_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        np_sh[i] <= '0;
        np_q[i]  <= '0;
      end
    end else begin
      np_done_q <= np_finish;
      if (np_abort) begin
        np_cnt <= '0;
        for (int i = 0; i < 2; i++) np_sh[i] <= '0;
      end else begin
        if (np_arm) np_cnt <= CW'(BIT - 1);
        if (np_shift) begin
          np_cnt <= np_finish ? '0 : np_cnt - CW'(1);
          for (int i = 0; i < 2; i++) np_sh[i] <= {np_sh[i][SW-2:0], np_lanes[i]};
        end
        if (np_finish) begin
          for (int i = 0; i < 2; i++) np_q[i] <= {np_sh[i], np_lanes[i]};
        end
      end
    end
  end

  // Aborts on both channels in the same cycle merge into one error pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= mp_abort | np_abort;
  end

  assign rx.o_mode      = mode_q;
  assign rx.o_a         = mp_q[5];
  assign rx.o_b         = mp_q[4];
  assign rx.o_prime     = mp_q[3];
  assign rx.o_Px        = mp_q[2];
  assign rx.o_Py        = mp_q[1];
  assign rx.o_m         = mp_q[0];
  assign rx.o_mP_done   = mp_done_q;
  assign rx.o_nPx       = np_q[1];
  assign rx.o_nPy       = np_q[0];
  assign rx.o_nP_done   = np_done_q;
  assign rx.o_frame_err = err_q;

endmodule
